// File: rtl/enable_burst_gen.sv
// Drives a downstream counter's enable with programmable bursts separated by gaps.
// Optional macro ENABLE_BURST_EXPECT_EN adds expected_count, a model of the 4-bit counter.
module enable_burst_gen #(
    parameter int LEN_W = 8,
    parameter int NB_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] burst_len,
    input  logic [LEN_W-1:0] gap_len,
    input  logic [NB_W-1:0]  num_bursts,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [NB_W-1:0]  burst_idx
`ifdef ENABLE_BURST_EXPECT_EN
    ,
    output logic [3:0]       expected_count
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] burst_len_q;
    logic [LEN_W-1:0] gap_len_q;
    logic [NB_W-1:0]  num_bursts_q;

    // cnt holds the cycles still to run in the current BURST/GAP after this one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            burst_len_q  <= '0;
            gap_len_q    <= '0;
            num_bursts_q <= '0;
            enable       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            burst_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        burst_len_q  <= burst_len;
                        gap_len_q    <= gap_len;
                        num_bursts_q <= num_bursts;
                        aborted      <= 1'b0;
                        burst_idx    <= '0;
                        if (burst_len == '0 || num_bursts == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state  <= BURST;
                            enable <= 1'b1;
                            busy   <= 1'b1;
                            cnt    <= burst_len - 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (abort) begin
                        state   <= DONE;
                        enable  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (cnt == '0) begin
                        if (burst_idx == num_bursts_q - 1'b1) begin
                            state  <= DONE;
                            enable <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else if (gap_len_q != '0) begin
                            state  <= GAP;
                            enable <= 1'b0;
                            cnt    <= gap_len_q - 1'b1;
                        end else begin
                            // zero gap: bursts merge and enable never drops
                            burst_idx <= burst_idx + 1'b1;
                            cnt       <= burst_len_q - 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (abort) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (cnt == '0) begin
                        state     <= BURST;
                        enable    <= 1'b1;
                        burst_idx <= burst_idx + 1'b1;
                        cnt       <= burst_len_q - 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ENABLE_BURST_EXPECT_EN
    // Mirrors the downstream counter: clears on accepted start, counts enabled edges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            expected_count <= 4'd0;
        end else if (state == IDLE && start) begin
            expected_count <= 4'd0;
        end else if (enable) begin
            expected_count <= expected_count + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_enable_burst_gen.sv
// Directed self-checking bench for enable_burst_gen; set ENABLE_BURST_EXPECT_EN to cover expected_count.
module tb_enable_burst_gen;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] burst_len;
    logic [7:0] gap_len;
    logic [3:0] num_bursts;
    logic       enable;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] burst_idx;
`ifdef ENABLE_BURST_EXPECT_EN
    logic [3:0] expected_count;
`endif

    int errors = 0;
    int checks = 0;

    enable_burst_gen #(.LEN_W(8), .NB_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .burst_len  (burst_len),
        .gap_len    (gap_len),
        .num_bursts (num_bursts),
        .enable     (enable),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .burst_idx  (burst_idx)
`ifdef ENABLE_BURST_EXPECT_EN
        ,
        .expected_count (expected_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Start is raised at a negedge and dropped at the next one, so on return
    // the outputs show the first cycle after the start edge.
    task automatic pulse_start(input logic [7:0] bl, input logic [7:0] gl, input logic [3:0] nb);
        @(negedge clk);
        burst_len  = bl;
        gap_len    = gl;
        num_bursts = nb;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_enable"}, enable, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_idx"}, burst_idx, 0);
    endtask

    logic [12:0] exp_en2;
    logic [3:0]  exp_idx2 [13];
    int          en_count;

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        burst_len  = '0;
        gap_len    = '0;
        num_bursts = '0;
        exp_en2  = 13'b1110011100111;
        exp_idx2 = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 2};

        #3;
        check_idle_outputs("reset");
        check("reset_aborted", aborted, 0);
        #9 reset = 1'b1;

        // single burst of 10, no gap
        pulse_start(8'd10, 8'd0, 4'd1);
        en_count = 0;
        for (int i = 0; i < 10; i++) begin
            if (enable === 1'b1 && busy === 1'b1) en_count++;
            tick;
        end
        check("t1_en_cycles", en_count, 10);
        check("t1_done", done, 1);
        check("t1_enable_off", enable, 0);
        check("t1_busy_off", busy, 0);
        tick;
        check("t1_done_clear", done, 0);

        // three bursts of 3 separated by 2-cycle gaps
        pulse_start(8'd3, 8'd2, 4'd3);
        for (int i = 0; i < 13; i++) begin
            check($sformatf("t2_en_%0d", i), enable, exp_en2[12-i]);
            check($sformatf("t2_idx_%0d", i), burst_idx, exp_idx2[i]);
            check($sformatf("t2_busy_%0d", i), busy, 1);
            tick;
        end
        check("t2_done", done, 1);
        check("t2_enable_off", enable, 0);

        // zero-length burst goes straight to DONE
        pulse_start(8'd0, 8'd1, 4'd5);
        check("t3_done", done, 1);
        check("t3_enable", enable, 0);
        check("t3_busy", busy, 0);
        tick;
        check("t3_done_clear", done, 0);
        check("t3_enable_later", enable, 0);

        // abort on the 5th enable cycle of an 8-cycle burst
        pulse_start(8'd8, 8'd4, 4'd2);
        repeat (4) tick;
        check("t4_en_before_abort", enable, 1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("t4_enable", enable, 0);
        check("t4_done", done, 1);
        check("t4_aborted", aborted, 1);
        check("t4_busy", busy, 0);
        repeat (3) tick;
        check("t4_aborted_held", aborted, 1);
        check("t4_done_clear", done, 0);
        pulse_start(8'd1, 8'd0, 4'd1);
        check("t4_aborted_cleared", aborted, 0);
        check("t4_restart_en", enable, 1);
        tick;
        check("t4_restart_done", done, 1);

        // reset asserted during the second gap
        pulse_start(8'd2, 8'd5, 4'd3);
        repeat (9) tick;
        check("t5_in_gap_en", enable, 0);
        check("t5_in_gap_busy", busy, 1);
        check("t5_in_gap_idx", burst_idx, 1);
        #2 reset = 1'b0;
        #1;
        check_idle_outputs("t5_async");
        tick;
        check("t5_no_done", done, 0);
        #2 reset = 1'b1;

        // merged bursts; a start while busy is ignored
        pulse_start(8'd2, 8'd0, 4'd2);
        check("t5_re_en", enable, 1);
        check("t5_re_idx0", burst_idx, 0);
        burst_len = 8'd0;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("t5_ign_en", enable, 1);
        check("t5_ign_idx", burst_idx, 0);
        tick;
        check("t5_merge_en", enable, 1);
        check("t5_merge_idx", burst_idx, 1);
        tick;
        check("t5_last_en", enable, 1);
        tick;
        check("t5_done", done, 1);
        check("t5_done_en", enable, 0);

        // abort in IDLE is ignored
        tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("t6_idle_abort_done", done, 0);
        check("t6_idle_abort_flag", aborted, 0);

        // start and abort together in IDLE: start wins
        burst_len  = 8'd2;
        gap_len    = 8'd0;
        num_bursts = 4'd1;
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        check("t6_start_wins_en", enable, 1);
        check("t6_start_wins_flag", aborted, 0);
        tick;
        tick;
        check("t6_done", done, 1);

`ifdef ENABLE_BURST_EXPECT_EN
        // 20 enabled edges wrap the 4-bit model to 4
        pulse_start(8'd20, 8'd0, 4'd1);
        check("t7_cleared", expected_count, 0);
        repeat (20) tick;
        check("t7_done", done, 1);
        check("t7_count", expected_count, 4);
        tick;
        check("t7_hold", expected_count, 4);
`else
        tick;
        check_idle_outputs("t7_idle");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/enable_burst_gen.md
Name: enable_burst_gen

Overview:
- Upstream stimulus stage for first_counter. It drives the counter's enable input with programmable bursts of enable-high cycles, separated by enable-low gaps.
- A single-cycle start pulse launches a sequence. busy, done and aborted report its progress to the controlling logic or bench.
- Replaces hand-coded enable sequencing (e.g. "enable for 10 negedges") with a reusable, cycle-exact block.

Parameters:
- LEN_W, 8, width of burst_len and gap_len (cycle counts, 0..2^LEN_W-1)
- NB_W, 4, width of num_bursts and burst_idx

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  launch request, sampled only in IDLE
- abort  input  1  synchronous abort of a running sequence
- burst_len  input  LEN_W  enable-high cycles per burst, latched at start
- gap_len  input  LEN_W  enable-low cycles between bursts, latched at start
- num_bursts  input  NB_W  bursts per sequence, latched at start
- enable  output  1  registered enable to the downstream counter
- busy  output  1  sequence in progress
- done  output  1  one-cycle completion pulse
- aborted  output  1  last sequence ended by abort; held until next accepted start
- burst_idx  output  NB_W  index of the current burst, 0..num_bursts-1

Behaviour:
- Reset: this is the already-decided clocking scheme. There is one clock, clk. reset is asynchronous and active-low.
  - While reset=0: state IDLE; enable=0, busy=0, done=0, aborted=0, burst_idx=0; all internal counters 0.
  - Deassertion is not synchronised internally; upstream reset logic releases reset away from the clk edge.
- States: IDLE, BURST, GAP, DONE. State is encoded internally; encoding is implementation-free.
- IDLE:
  - start=1 at edge k latches burst_len, gap_len and num_bursts, and clears aborted.
  - If burst_len=0 or num_bursts=0: go to DONE (done=1 at cycle k+1, enable never asserted).
  - Otherwise: go to BURST. From cycle k+1, enable=1, busy=1, burst_idx=0.
- start outside IDLE is ignored, with no queuing.
- BURST:
  - enable=1 for exactly burst_len consecutive cycles.
  - After the last cycle, if burst_idx=num_bursts-1, go to DONE.
  - Otherwise, if gap_len>0, go to GAP.
  - Otherwise (gap_len=0), stay in BURST with burst_idx+1; enable stays continuously high and bursts merge.
- GAP:
  - enable=0, busy=1, for exactly gap_len cycles.
  - Then go to BURST with burst_idx incremented.
- DONE:
  - Lasts one cycle: done=1, busy=0, enable=0. Always followed by IDLE.
- Latency: the first enable-high cycle is the cycle immediately after the start edge. done is asserted the cycle after the last enable-high cycle.
- Total enable-high cycles = burst_len*num_bursts (full-width arithmetic internally, no overflow).
- abort=1 in BURST or GAP at edge j:
  - Next cycle enters DONE with enable=0 and done=1; aborted=1 from then on.
  - abort takes priority over burst and gap completion in the same cycle.
  - abort in IDLE or DONE is ignored.
- start and abort both high in IDLE: start wins; abort is ignored that cycle.
- Reset asserted mid-sequence: all outputs drop to reset values immediately (asynchronously). No done pulse is generated.
- Latched parameters are stable for the whole sequence. Input changes while busy have no effect.
- Outputs are registered and glitch-free. enable changes only on the clk rising edge.

Optional Feature:
- Macro: ENABLE_BURST_EXPECT_EN
- Defined: adds output expected_count[3:0], a model of the downstream 4-bit counter.
  - Cleared to 0 on an accepted start and on reset.
  - Increments by 1 (wrapping mod 16) on each edge where enable=1.
  - Holds its value through DONE and IDLE.
  - Used by the bench as the compare reference.
- Not defined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset low, then start with burst_len=10, gap_len=0, num_bursts=1 -> enable high for exactly 10 cycles from the cycle after start; done=1 for one cycle immediately after; busy high for those 10 cycles only.
- burst_len=3, gap_len=2, num_bursts=3 -> enable pattern 1,1,1,0,0,1,1,1,0,0,1,1,1 then done; burst_idx reads 0, 1, 2 across the bursts.
- burst_len=0, num_bursts=5 -> enable never high; done=1 on the cycle after start; busy stays 0.
- burst_len=8, num_bursts=2, gap_len=4; abort at the 5th enable cycle -> enable=0 and done=1 next cycle; aborted=1 held; a new start clears aborted.
- Assert reset (low) during a GAP -> enable, busy, done and burst_idx are 0 immediately; after release, start accepted normally; start pulses sent while busy produce no effect.
- ENABLE_BURST_EXPECT_EN defined, burst_len=20, num_bursts=1 -> expected_count ends at 4 after wrapping through 15->0, matching the downstream counter_out.
